luma_hfilter_pipe: RTL

Parametrised HEVC luma horizontal sub-pixel filter. Accepts one reference row of BLK_W+7 integer pixels per transaction over a valid/ready handshake, plus a per-row fractional phase. Produces BLK_W interpolated samples, computed LANES at a time by an 8-tap FIR engine. It sits between the reference-row fetch and the vertical filter stage of the sub-pixel interpolation path, and generalises the fixed 8-pixel A/B/C filter to any block width, lane count and phase.

---
 rtl/luma_hfilter_pipe.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/luma_hfilter_pipe.sv
// HEVC luma horizontal sub-pixel 8-tap filter, LANES samples per cycle over a BLK_W-wide row.
// Optional feature macro: LUMA_HFILT_RAW16_EN (16-bit unrounded sums for the vertical stage).
module luma_hfilter_pipe #(
    parameter int BLK_W = 8,
    parameter int BLK_H = 8,
    parameter int LANES = 4,
    parameter int PIX_W = 8,
`ifdef LUMA_HFILT_RAW16_EN
    localparam int OUT_W = 16
`else
    localparam int OUT_W = PIX_W
`endif
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [(BLK_W+7)*PIX_W-1:0]   in_row,
    input  logic [1:0]                   in_frac,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [BLK_W*OUT_W-1:0]       out_row,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         out_last,
    output logic                         busy
);
    localparam int NSTEP = BLK_W / LANES;
    localparam int CNT_W = (NSTEP > 1) ? $clog2(NSTEP) : 1;
    localparam int ROW_W = (BLK_H > 1) ? $clog2(BLK_H) : 1;

    if (BLK_W % LANES != 0) begin : g_bad_lanes
        $error("BLK_W must be a multiple of LANES");
    end
    if (PIX_W != 8) begin : g_bad_pix
        $error("only PIX_W=8 is supported");
    end

    typedef enum logic [1:0] {IDLE = 2'd0, FILT = 2'd1, HOLD = 2'd2} state_t;

    state_t                       state_q, state_d;
    logic [CNT_W-1:0]             lane_cnt_q, lane_cnt_d;
    logic [ROW_W-1:0]             row_cnt_q, row_cnt_d;
    logic [(BLK_W+7)*PIX_W-1:0]   row_q, row_d;
    logic [1:0]                   frac_q, frac_d;
    logic [BLK_W*OUT_W-1:0]       out_row_q, out_row_d;

    // Tap k of the phase table, sign-extended; byte k of each word holds t_k.
    function automatic logic signed [17:0] coef(input logic [1:0] frac, input int k);
        logic [63:0] tab;
        logic [7:0]  c;
        case (frac)
            2'd1:    tab = 64'h0001_FB11_3AF6_04FF;
            2'd2:    tab = 64'hFF04_F528_28F5_04FF;
            2'd3:    tab = 64'hFF04_F63A_11FB_0100;
            default: tab = 64'h0000_0000_0000_0000;
        endcase
        c = tab[k*8 +: 8];
        return {{10{c[7]}}, c};
    endfunction

    function automatic logic [OUT_W-1:0] filt_sample(input logic [8*PIX_W-1:0] win,
                                                     input logic [1:0] frac);
        logic signed [17:0] sum;
        logic signed [17:0] rnd;
        logic [OUT_W-1:0]   res;
        sum = 18'sd0;
        for (int k = 0; k < 8; k++) begin
            sum = sum + coef(frac, k) * $signed({{(18-PIX_W){1'b0}}, win[k*PIX_W +: PIX_W]});
        end
        rnd = (sum + 18'sd32) >>> 6;
`ifdef LUMA_HFILT_RAW16_EN
        if (frac == 2'd0) begin
            res = {{(OUT_W-PIX_W-6){1'b0}}, win[3*PIX_W +: PIX_W], 6'b000000};
        end else begin
            res = sum[15:0];
        end
`else
        if (frac == 2'd0) begin
            res = win[3*PIX_W +: PIX_W];
        end else if (rnd < 18'sd0) begin
            res = '0;
        end else if (rnd > 18'sd255) begin
            res = '1;
        end else begin
            res = rnd[OUT_W-1:0];
        end
`endif
        return res;
    endfunction

    // Next-state, lane datapath and row counter.
    always_comb begin
        state_d    = state_q;
        lane_cnt_d = lane_cnt_q;
        row_cnt_d  = row_cnt_q;
        row_d      = row_q;
        frac_d     = frac_q;
        out_row_d  = out_row_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    row_d      = in_row;
                    frac_d     = in_frac;
                    lane_cnt_d = '0;
                    state_d    = FILT;
                end else begin
                    state_d    = IDLE;
                end
            end
            FILT: begin
                for (int l = 0; l < LANES; l++) begin
                    int idx;
                    idx = int'(lane_cnt_q) * LANES + l;
                    out_row_d[idx*OUT_W +: OUT_W] = filt_sample(row_q[idx*PIX_W +: 8*PIX_W], frac_q);
                end
                if (lane_cnt_q == CNT_W'(NSTEP - 1)) begin
                    lane_cnt_d = '0;
                    state_d    = HOLD;
                end else begin
                    lane_cnt_d = lane_cnt_q + CNT_W'(1);
                end
            end
            HOLD: begin
                if (out_ready) begin
                    // Row counter wraps at the block height so out_last repeats per block.
                    if (row_cnt_q == ROW_W'(BLK_H - 1)) begin
                        row_cnt_d = '0;
                    end else begin
                        row_cnt_d = row_cnt_q + ROW_W'(1);
                    end
                    state_d = IDLE;
                end else begin
                    state_d = HOLD;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            lane_cnt_q <= '0;
            row_cnt_q  <= '0;
            row_q      <= '0;
            frac_q     <= 2'd0;
            out_row_q  <= '0;
        end else begin
            state_q    <= state_d;
            lane_cnt_q <= lane_cnt_d;
            row_cnt_q  <= row_cnt_d;
            row_q      <= row_d;
            frac_q     <= frac_d;
            out_row_q  <= out_row_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == HOLD);
    assign out_last  = (state_q == HOLD) && (row_cnt_q == ROW_W'(BLK_H - 1));
    assign busy      = (state_q == FILT) || (state_q == HOLD);
    assign out_row   = out_row_q;

endmodule
